ll_mrk_stb_gen: RTL and testbench
=================================

// Module: ll_mrk_stb_gen
//
// PURPOSE
// - Generates the per-word USER marker and USER strobe bits for the logic link TX path.
// - Sits directly upstream of the auto-sync stage and drives its tx_mrk_userbit / tx_stb_userbit inputs.
// - Marker tracks gearbox word boundaries (full/half/quarter rate).
// - Strobe repeats every N beats on a selectable word of the beat.
//
// PARAMETERS
// - MARKER_WIDTH  1  width of tx_mrk_userbit; every bit carries the same marker value.
// - STB_CNT_W     16 width of the strobe interval counter.
//
// PORTS
// - clk_wr          in   1             TX write clock; the only clock.
// - rst_wr_n        in   1             asynchronous, active-low reset.
// - tx_enable       in   1             level; high = generate marker/strobe (driven from tx_online).
// - resync          in   1             single-cycle pulse; restarts word and beat counters.
// - gb_ratio        in   2             0 = 1 word/beat, 1 = 2 words, 2 = 4 words, 3 = treated as 4.
// - stb_interval    in   STB_CNT_W     beats between strobes; 0 = strobe disabled.
// - stb_word_sel    in   2             word index within the beat that carries the strobe.
// - tx_mrk_userbit  out  MARKER_WIDTH  marker; all bits high on the last word of each beat.
// - tx_stb_userbit  out  1             strobe; high for one word per strobe beat.
// - word_idx        out  2             current word index within the beat.
// - gen_active      out  1             high while in RUN.
//
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; counters 0.
// - Outputs are decoded from registered state/counters only. There is no combinational input-to-output path.
// - Config latch:
//   - gb_ratio, stb_interval and stb_word_sel are captured into shadow registers on the IDLE->RUN transition.
//   - Changes while in RUN are ignored until the next IDLE->RUN.
//   - stb_word_sel >= words/beat is clamped to the last word (words-1).
// - FSM states: IDLE, RUN.
//   - IDLE:
//     - outputs 0.
//     - If tx_enable==1 in cycle T: go to RUN, word_cnt=0, beat_cnt=0, shadows loaded.
//     - Word 0 is visible at T+1.
//   - RUN:
//     - word_cnt increments each cycle and wraps at words-1.
//     - beat_cnt increments when word_cnt wraps; it wraps to 0 after stb_interval-1.
//     - If stb_interval==1, beat_cnt stays 0, so every beat carries a strobe.
//     - If tx_enable==0 in cycle T: IDLE at T+1, outputs 0 at T+1 (no beat completion).
// - Decode while in RUN:
//   - tx_mrk_userbit = {MARKER_WIDTH{word_cnt==words-1}}.
//   - tx_stb_userbit = (stb_interval!=0) && (beat_cnt==0) && (word_cnt==stb_word_sel).
//   - word_idx = word_cnt.
//   - gen_active = 1.
// - Latency: first marker T+words; first strobe T+1+stb_word_sel.
// - resync in RUN:
//   - Next cycle word_cnt=0, beat_cnt=0.
//   - Shadows are not reloaded.
//   - resync in IDLE is ignored.
//   - If resync and tx_enable==0 occur together, disable wins (go to IDLE).
// - Width rules:
//   - beat_cnt is STB_CNT_W bits.
//   - Comparison against stb_interval-1 is done in STB_CNT_W bits.
//   - stb_interval==0 never advances the strobe decode.
// - Reset mid-RUN: async return to IDLE, all outputs 0 immediately.
//
// STRUCTURE
// - Package ll_mrk_stb_pkg:
//   - typedef enum logic {IDLE, RUN} mrk_stb_state_t.
//   - gb_ratio code localparams GB_FULL=2'd0, GB_HALF=2'd1, GB_QUARTER=2'd2.
//   - function words_per_beat(gb_ratio) returning 1/2/4.
// - No sub-module required.
// - word_cnt and beat_cnt are inline counters in this module.
//
// TESTING
// - Reset: hold rst_wr_n=0 with tx_enable=1 -> all outputs 0; release -> RUN one cycle later.
// - Quarter rate, interval 3, sel 1, enable at T:
//   - markers at T+4, T+8, T+12, ...
//   - strobes at T+2, T+14, T+26.
// - Full rate, interval 1, sel 3 (clamped to 0) -> marker and strobe high on every cycle from T+1.
// - Half rate, interval 0:
//   - markers at T+2, T+4, ...
//   - strobe never asserted over 100 cycles.
// - Mid-RUN gb_ratio change 2->0 -> marker period stays 4 until disable/re-enable, then becomes 1.
// - resync at word 2 of a quarter-rate beat -> word_idx=0 next cycle, marker 3 cycles after that.
// - resync and tx_enable=0 in the same cycle -> IDLE, outputs 0 next cycle.

Source files
------------

// File: rtl/ll_mrk_stb_gen_pkg.sv
// Shared types and helpers for the logic-link USER marker/strobe generator.
package ll_mrk_stb_pkg;

  localparam int unsigned WORD_IDX_W = 2;
  localparam int unsigned WPB_W      = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mrk_stb_state_t;

  localparam logic [1:0] GB_FULL    = 2'd0;
  localparam logic [1:0] GB_HALF    = 2'd1;
  localparam logic [1:0] GB_QUARTER = 2'd2;

  // Code 3 is treated as quarter rate.
  function automatic logic [WPB_W-1:0] words_per_beat(input logic [1:0] gb_ratio);
    case (gb_ratio)
      GB_FULL: return WPB_W'(1);
      GB_HALF: return WPB_W'(2);
      default: return WPB_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/ll_mrk_stb_gen_if.sv
// Config and per-word USER bit bundle between the TX controller and the marker/strobe generator.
interface ll_mrk_stb_gen_if
  import ll_mrk_stb_pkg::*;
#(
  parameter int unsigned MARKER_WIDTH = 1,
  parameter int unsigned STB_CNT_W    = 16
);

  logic                    tx_enable;
  logic                    resync;
  logic [1:0]              gb_ratio;
  logic [STB_CNT_W-1:0]    stb_interval;
  logic [WORD_IDX_W-1:0]   stb_word_sel;
  logic [MARKER_WIDTH-1:0] tx_mrk_userbit;
  logic                    tx_stb_userbit;
  logic [WORD_IDX_W-1:0]   word_idx;
  logic                    gen_active;

  modport master (
    output tx_enable, resync, gb_ratio, stb_interval, stb_word_sel,
    input  tx_mrk_userbit, tx_stb_userbit, word_idx, gen_active
  );

  modport slave (
    input  tx_enable, resync, gb_ratio, stb_interval, stb_word_sel,
    output tx_mrk_userbit, tx_stb_userbit, word_idx, gen_active
  );

endinterface

// File: rtl/ll_mrk_stb_gen.sv
// USER marker/strobe generator: marks the last word of each gearbox beat and strobes
// one selectable word every stb_interval beats.
module ll_mrk_stb_gen
  import ll_mrk_stb_pkg::*;
#(
  parameter int unsigned MARKER_WIDTH = 1,
  parameter int unsigned STB_CNT_W    = 16
) (
  input  logic                clk_wr,
  input  logic                rst_wr_n,
  ll_mrk_stb_gen_if.slave     bus
);

  mrk_stb_state_t          state_q, state_d;
  logic [WORD_IDX_W-1:0]   word_q, word_d;
  logic [STB_CNT_W-1:0]    beat_q, beat_d;
  logic [WORD_IDX_W-1:0]   last_word_q, last_word_d;
  logic [STB_CNT_W-1:0]    intv_q, intv_d;
  logic [WORD_IDX_W-1:0]   sel_q, sel_d;

  logic                    mrk_q, mrk_d;
  logic                    stb_q, stb_d;
  logic [WORD_IDX_W-1:0]   idx_q, idx_d;
  logic                    act_q, act_d;

  logic [WORD_IDX_W-1:0]   cfg_last_word;
  logic [WORD_IDX_W-1:0]   cfg_sel;
  logic                    beat_wrap;

  // Live config as it would be captured on IDLE->RUN, with the strobe word clamped.
  assign cfg_last_word = WORD_IDX_W'(words_per_beat(bus.gb_ratio) - WPB_W'(1));
  assign cfg_sel       = (bus.stb_word_sel > cfg_last_word) ? cfg_last_word : bus.stb_word_sel;
  assign beat_wrap     = (intv_q <= STB_CNT_W'(1)) || (beat_q == intv_q - STB_CNT_W'(1));

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Outputs are registered from next-state values so word 0 appears the cycle after enable.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    beat_d      = beat_q;
    last_word_d = last_word_q;
    intv_d      = intv_q;
    sel_d       = sel_q;
    mrk_d       = 1'b0;
    stb_d       = 1'b0;
    idx_d       = '0;
    act_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.tx_enable) begin
          state_d     = RUN;
          word_d      = '0;
          beat_d      = '0;
          last_word_d = cfg_last_word;
          intv_d      = bus.stb_interval;
          sel_d       = cfg_sel;
        end
      end
      RUN: begin
        if (!bus.tx_enable) begin
          state_d = IDLE;
          word_d  = '0;
          beat_d  = '0;
        end else if (bus.resync) begin
          word_d = '0;
          beat_d = '0;
        end else if (word_q == last_word_q) begin
          word_d = '0;
          beat_d = beat_wrap ? '0 : beat_q + STB_CNT_W'(1);
        end else begin
          word_d = word_q + WORD_IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == RUN) begin
      mrk_d = (word_d == last_word_d);
      stb_d = (intv_d != '0) && (beat_d == '0) && (word_d == sel_d);
      idx_d = word_d;
      act_d = 1'b1;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      word_q      <= '0;
      beat_q      <= '0;
      last_word_q <= '0;
      intv_q      <= '0;
      sel_q       <= '0;
      mrk_q       <= 1'b0;
      stb_q       <= 1'b0;
      idx_q       <= '0;
      act_q       <= 1'b0;
    end else begin
      word_q      <= word_d;
      beat_q      <= beat_d;
      last_word_q <= last_word_d;
      intv_q      <= intv_d;
      sel_q       <= sel_d;
      mrk_q       <= mrk_d;
      stb_q       <= stb_d;
      idx_q       <= idx_d;
      act_q       <= act_d;
    end
  end

  assign bus.tx_mrk_userbit = {MARKER_WIDTH{mrk_q}};
  assign bus.tx_stb_userbit = stb_q;
  assign bus.word_idx       = idx_q;
  assign bus.gen_active     = act_q;

endmodule

// File: tb/tb_ll_mrk_stb_gen.sv
// Scoreboard bench for ll_mrk_stb_gen: a cycle-count reference model predicts each
// cycle's outputs, a separate monitor pops and compares after every clock edge.
module tb_ll_mrk_stb_gen;

  localparam int unsigned MW = 2;
  localparam int unsigned CW = 16;

  typedef struct packed {
    logic [MW-1:0] mrk;
    logic          stb;
    logic [1:0]    idx;
    logic          act;
  } obs_t;

  logic clk_wr   = 1'b0;
  logic rst_wr_n = 1'b0;
  logic mon_en   = 1'b0;

  ll_mrk_stb_gen_if #(.MARKER_WIDTH(MW), .STB_CNT_W(CW)) bus ();

  ll_mrk_stb_gen #(.MARKER_WIDTH(MW), .STB_CNT_W(CW)) dut (
    .clk_wr   (clk_wr),
    .rst_wr_n (rst_wr_n),
    .bus      (bus)
  );

  always #5 clk_wr = ~clk_wr;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: cycles elapsed in RUN since start/resync, plus latched config.
  bit   m_run = 1'b0;
  int   m_n   = 0;
  int   m_w   = 1;
  int   m_iv  = 0;
  int   m_sel = 0;

  function automatic obs_t model_out();
    obs_t o;
    int   word;
    int   beat;
    o = '0;
    if (m_run) begin
      word  = m_n % m_w;
      beat  = (m_iv == 0) ? 0 : (m_n / m_w) % m_iv;
      o.mrk = (word == m_w - 1) ? {MW{1'b1}} : '0;
      o.stb = (m_iv != 0) && (beat == 0) && (word == m_sel);
      o.idx = 2'(word);
      o.act = 1'b1;
    end
    return o;
  endfunction

  task automatic step(input logic rst, input logic en, input logic rs,
                      input logic [1:0] gr, input logic [CW-1:0] iv, input logic [1:0] sel);
    @(negedge clk_wr);
    rst_wr_n         = rst;
    bus.tx_enable    = en;
    bus.resync       = rs;
    bus.gb_ratio     = gr;
    bus.stb_interval = iv;
    bus.stb_word_sel = sel;
    if (!rst) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_n   = 0;
        m_w   = (gr == 2'd0) ? 1 : (gr == 2'd1) ? 2 : 4;
        m_iv  = int'(iv);
        m_sel = (int'(sel) >= m_w) ? m_w - 1 : int'(sel);
      end
    end else if (!en) begin
      m_run = 1'b0;
    end else if (rs) begin
      m_n = 0;
    end else begin
      m_n++;
    end
    exp_q.push_back(model_out());
    mon_en = 1'b1;
  endtask

  task automatic run(input int n, input logic [1:0] gr, input logic [CW-1:0] iv, input logic [1:0] sel);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, gr, iv, sel);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 2'd0, '0, 2'd0);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.mrk = bus.tx_mrk_userbit;
    o.stb = bus.tx_stb_userbit;
    o.idx = bus.word_idx;
    o.act = bus.gen_active;
    return o;
  endfunction

  task automatic cmp(input string nm, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got mrk=%b stb=%b idx=%0d act=%b, expected mrk=%b stb=%b idx=%0d act=%b",
               nm, $time, got.mrk, got.stb, got.idx, got.act, want.mrk, want.stb, want.idx, want.act);
    end
  endtask

  // Monitor: per-cycle scoreboard compare, plus an immediate check on async reset assertion.
  initial begin
    obs_t want;
    wait (mon_en);
    forever begin
      @(posedge clk_wr or negedge rst_wr_n);
      #1;
      if (clk_wr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow t=%0t got empty queue, expected an entry", $time);
        end else begin
          want = exp_q.pop_front();
          cmp("cycle_outputs", sample(), want);
        end
      end else begin
        cmp("async_reset_outputs", sample(), '0);
      end
    end
  end

  initial begin
    bus.tx_enable    = 1'b1;
    bus.resync       = 1'b0;
    bus.gb_ratio     = 2'd0;
    bus.stb_interval = '0;
    bus.stb_word_sel = 2'd0;

    // Reset held with enable high, then release into quarter rate, interval 3, sel 1.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd2, CW'(3), 2'd1);
    run(30, 2'd2, CW'(3), 2'd1);
    idle(2);

    // Full rate, interval 1, sel 3 clamps to word 0: marker and strobe every cycle.
    run(10, 2'd0, CW'(1), 2'd3);
    idle(2);

    // Half rate with strobe disabled.
    run(100, 2'd1, CW'(0), 2'd0);
    idle(2);

    // Ratio change mid-RUN is ignored until re-enable.
    run(2, 2'd2, CW'(2), 2'd3);
    run(12, 2'd0, CW'(2), 2'd0);
    idle(1);
    run(8, 2'd0, CW'(2), 2'd0);
    idle(2);

    // Resync while word_cnt is 2 of a quarter-rate beat.
    run(3, 2'd2, CW'(2), 2'd2);
    step(1'b1, 1'b1, 1'b1, 2'd2, CW'(2), 2'd2);
    run(9, 2'd2, CW'(2), 2'd2);

    // Resync together with disable: disable wins.
    step(1'b1, 1'b0, 1'b1, 2'd2, CW'(2), 2'd2);
    idle(2);

    // Async reset in the middle of RUN.
    run(5, 2'd1, CW'(2), 2'd1);
    step(1'b0, 1'b1, 1'b0, 2'd1, CW'(2), 2'd1);
    run(6, 2'd1, CW'(2), 2'd1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 9) == 0),
           2'($urandom_range(0, 3)),
           CW'($urandom_range(0, 5)),
           2'($urandom_range(0, 3)));
    end
    idle(2);

    @(posedge clk_wr);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
